// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the control unit and the fetch-stage program counter.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000;

  // Code 2'b11 is reserved and decodes as sequential fetch.
  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_TARGET = 2'b01,
    PCSRC_ALU    = 2'b10
  } pc_src_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selector: sequential, branch/JAL target, or JALR target from the ALU.
module pc_next_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH = riscv_pkg::XLEN
) (
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] PCPlus4,
  input  logic [WIDTH-1:0] PCTarget,
  input  logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] PCNext
);

  // Only the selected source reaches PCNext, so X on an unused source stays contained.
  always_comb begin
    PCNext = PCPlus4;
    case (pc_src_e'(PCSrc))
      PCSRC_TARGET: PCNext = PCTarget;
      PCSRC_ALU:    PCNext = ALUResult;
      default:      PCNext = PCPlus4;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// RV32 fetch-stage PC register with async active-low reset, +4 adder and next-PC selection.
module program_counter
  import riscv_pkg::*;
#(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_ADDR = riscv_pkg::RESET_ADDR
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
);

  logic [XLEN-1:0] pc_next;

  // Modulo 2^XLEN: the top word address rolls over to zero with no flag.
  assign PCPlus4 = PC + XLEN'(4);

  pc_next_mux #(
    .WIDTH(XLEN)
  ) u_pc_next_mux (
    .PCSrc    (PCSrc),
    .PCPlus4  (PCPlus4),
    .PCTarget (PCTarget),
    .ALUResult(ALUResult),
    .PCNext   (pc_next)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) PC <= RESET_ADDR;
    else        PC <= pc_next;
  end

endmodule

// File: tb/tb_program_counter.sv
// Randomized self-checking bench for program_counter against a next-PC reference model.
module tb_program_counter;

  logic        CLK;
  logic        Reset;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  int vectors;
  int miscompares;
  logic [31:0] model_pc;
  logic [31:0] exp_q[$];

  program_counter dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .PCSrc    (PCSrc),
    .PCTarget (PCTarget),
    .ALUResult(ALUResult),
    .PC       (PC),
    .PCPlus4  (PCPlus4)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at the negedge, model updates at the posedge, check at the next negedge.
  task automatic step(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                      input bit x_unused);
    logic [31:0] e;
    PCSrc     = src;
    PCTarget  = tgt;
    ALUResult = alu;
    if (x_unused && src != 2'd1) PCTarget  = 'x;
    if (x_unused && src != 2'd2) ALUResult = 'x;
    @(posedge CLK);
    case (src)
      2'd1:    model_pc = tgt;
      2'd2:    model_pc = alu;
      default: model_pc = model_pc + 32'd4;
    endcase
    exp_q.push_back(model_pc);
    @(negedge CLK);
    e = exp_q.pop_front();
    check_eq("pc", PC, e);
    check_eq("pc_plus4", PCPlus4, e + 32'd4);
  endtask

  // Called just after a negedge: pulse reset between edges and check its immediate effect.
  task automatic mid_reset();
    Reset = 1'b0;
    #2;
    model_pc = 32'h0;
    check_eq("async_rst_pc", PC, model_pc);
    check_eq("async_rst_pc_plus4", PCPlus4, model_pc + 32'd4);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    vectors     = 0;
    miscompares = 0;
    model_pc    = 32'h0;
    Reset       = 1'b0;
    PCSrc       = 2'd0;
    PCTarget    = 32'h0;
    ALUResult   = 32'h0;

    // Reset applied before any clock edge.
    #3;
    check_eq("reset_pc", PC, 32'h0);
    check_eq("reset_pc_plus4", PCPlus4, 32'h4);
    @(negedge CLK);
    check_eq("reset_held_pc", PC, 32'h0);
    Reset = 1'b1;

    // Sequential after release: 4, 8, C, 10.
    for (int i = 0; i < 4; i++) step(2'd0, 32'h0, 32'h0, 1'b0);
    check_eq("seq_reached_10", PC, 32'h10);

    // Branch then sequential.
    step(2'd1, 32'h50, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'd0, 32'h1234, 32'h0, 1'b0);
    check_eq("branch_seq_5c", PC, 32'h5C);

    // Jump via ALU, PCTarget churning.
    step(2'd2, 32'hDEAD_BEE0, 32'h100, 1'b0);
    for (int i = 0; i < 2; i++) step(2'd0, $urandom, $urandom, 1'b0);
    check_eq("jump_seq_108", PC, 32'h108);

    // Async reset mid-run then release.
    mid_reset();
    step(2'd0, 32'h0, 32'h0, 1'b0);
    check_eq("post_reset_4", PC, 32'h4);

    // Wrap through the top of the address space and reserved select.
    step(2'd1, 32'hFFFF_FFFC, 32'h0, 1'b0);
    check_eq("wrap_pc_plus4", PCPlus4, 32'h0);
    step(2'd3, 32'h80, 32'h90, 1'b0);
    check_eq("wrap_reserved_pc", PC, 32'h0);

    // X on unselected sources.
    for (int i = 0; i < 4; i++) step(2'd0, 32'h0, 32'h0, 1'b1);
    step(2'd1, 32'h0000_2002, 32'h0, 1'b1);
    step(2'd2, 32'h0, 32'h0000_3001, 1'b1);

    // Randomized run with occasional mid-cycle resets.
    for (int i = 0; i < 300; i++) begin
      src = 2'($urandom_range(0, 3));
      tgt = $urandom;
      alu = $urandom;
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) alu = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      step(src, tgt, alu, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
